// File: rtl/truth_table_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweep_ctrl_if
// Description : Bundle between the sweep controller and the host/bench side.
//               Carries the start request, both core outputs and all sweep
//               results. When SWEEP_SIG_EN is defined, it also carries the
//               16-bit signature output o_sig.
//               slave  : controller side (truth_table_sweep_ctrl)
//               master : host/bench side, which drives the inputs and reads
//                        the results
// Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_sweep_ctrl_if #(
   parameter int N_IN  = 8,
   parameter int N_OUT = 5
);
   logic              i_start;
   logic              i_stop_on_err;
   logic [N_OUT-1:0]  i_y_ddnf;
   logic [N_OUT-1:0]  i_y_dknf;
   logic [N_IN-1:0]   o_x;
   logic              o_busy;
   logic              o_done;
   logic              o_error;
   logic [N_IN:0]     o_err_count;
   logic [N_IN-1:0]   o_err_vec;
   logic [N_OUT-1:0]  o_err_ddnf;
   logic [N_OUT-1:0]  o_err_dknf;
`ifdef SWEEP_SIG_EN
   logic [15:0]       o_sig;
`endif

   modport slave (
      input  i_start, i_stop_on_err, i_y_ddnf, i_y_dknf,
      output o_x, o_busy, o_done, o_error, o_err_count, o_err_vec,
             o_err_ddnf, o_err_dknf
`ifdef SWEEP_SIG_EN
      , output o_sig
`endif
   );

   modport master (
      output i_start, i_stop_on_err, i_y_ddnf, i_y_dknf,
      input  o_x, o_busy, o_done, o_error, o_err_count, o_err_vec,
             o_err_ddnf, o_err_dknf
`ifdef SWEEP_SIG_EN
      , input o_sig
`endif
   );
endinterface
`default_nettype wire

// File: rtl/truth_table_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweep_ctrl
// Description : Sweeps every N_IN-bit input vector through two implementations
//               of the same truth-table function (DDNF and DKNF forms) and
//               compares their outputs. Each vector is held for SETTLE_CYCLES
//               cycles and then compared for one cycle. The controller counts
//               mismatching vectors, captures the first failure and can
//               optionally halt on the first mismatch.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - truth_table_sweep_ctrl_if.slave carrying
//                      i_start / i_stop_on_err / i_y_ddnf / i_y_dknf (in) and
//                      o_x / o_busy / o_done / o_error / o_err_count /
//                      o_err_vec / o_err_ddnf / o_err_dknf (out)
// Option      : SWEEP_SIG_EN - adds a CRC-16 (0x1021) style signature o_sig,
//               which is folded over i_y_ddnf on every compare cycle
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweep_ctrl #(
   parameter int N_IN          = 8,
   parameter int N_OUT         = 5,
   parameter int SETTLE_CYCLES = 1
) (
   input  wire logic                clk,
   input  wire logic                rst,
   truth_table_sweep_ctrl_if.slave  bus
);

   // Settle counter is at least one bit wide, even when SETTLE_CYCLES == 1.
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [CW-1:0]   c_SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0]   c_CNT_ONE     = CW'(1);
   localparam logic [N_IN-1:0] c_X_ONE       = N_IN'(1);
   localparam logic [N_IN:0]   c_ERR_ONE     = (N_IN + 1)'(1);

   localparam logic [2:0] c_ST_IDLE    = 3'd0;
   localparam logic [2:0] c_ST_SETTLE  = 3'd1;
   localparam logic [2:0] c_ST_COMPARE = 3'd2;
   localparam logic [2:0] c_ST_DONE    = 3'd3;
   localparam logic [2:0] c_ST_FAIL    = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [N_IN-1:0]   x_q, x_d;
   logic              stop_q, stop_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [N_IN:0]     err_count_q, err_count_d;
   logic [N_IN-1:0]   err_vec_q, err_vec_d;
   logic [N_OUT-1:0]  err_ddnf_q, err_ddnf_d;
   logic [N_OUT-1:0]  err_dknf_q, err_dknf_d;

   logic w_idle_like;
   logic w_start_accept;
   logic w_mismatch;
   logic w_last_vec;

   // Start is honoured only while no sweep is running.
   assign w_idle_like    = (state_q == c_ST_IDLE) || (state_q == c_ST_DONE) ||
                           (state_q == c_ST_FAIL);
   assign w_start_accept = w_idle_like && bus.i_start;
   assign w_mismatch     = (bus.i_y_ddnf != bus.i_y_dknf);
   assign w_last_vec     = &x_q;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= c_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_IDLE, c_ST_DONE, c_ST_FAIL: begin
            if (bus.i_start) state_d = c_ST_SETTLE;
         end
         c_ST_SETTLE: begin
            if (cnt_q == '0) state_d = c_ST_COMPARE;
         end
         c_ST_COMPARE: begin
            if (w_mismatch && stop_q) state_d = c_ST_FAIL;
            else if (w_last_vec)      state_d = c_ST_DONE;
            else                      state_d = c_ST_SETTLE;
         end
         default: state_d = c_ST_IDLE;
      endcase
   end

   // ---------------------------------------------------- output / datapath comb
   always_comb begin
      cnt_d       = cnt_q;
      x_d         = x_q;
      stop_d      = stop_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      err_count_d = err_count_q;
      err_vec_d   = err_vec_q;
      err_ddnf_d  = err_ddnf_q;
      err_dknf_d  = err_dknf_q;

      if (w_start_accept) begin
         x_d         = '0;
         cnt_d       = c_SETTLE_LOAD;
         stop_d      = bus.i_stop_on_err;
         busy_d      = 1'b1;
         done_d      = 1'b0;
         error_d     = 1'b0;
         err_count_d = '0;
         err_vec_d   = '0;
         err_ddnf_d  = '0;
         err_dknf_d  = '0;
      end else if (state_q == c_ST_SETTLE) begin
         if (cnt_q != '0) cnt_d = cnt_q - c_CNT_ONE;
      end else if (state_q == c_ST_COMPARE) begin
         if (w_mismatch) begin
            err_count_d = err_count_q + c_ERR_ONE;
            error_d     = 1'b1;
            // Capture only the first failing vector of this sweep.
            if (!error_q) begin
               err_vec_d  = x_q;
               err_ddnf_d = bus.i_y_ddnf;
               err_dknf_d = bus.i_y_dknf;
            end
         end
         if (state_d == c_ST_SETTLE) begin
            x_d   = x_q + c_X_ONE;
            cnt_d = c_SETTLE_LOAD;
         end else begin
            // Terminal: o_x holds either the failing vector or all ones.
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // ------------------------------------------------------- datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         x_q         <= '0;
         stop_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_count_q <= '0;
         err_vec_q   <= '0;
         err_ddnf_q  <= '0;
         err_dknf_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         stop_q      <= stop_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_count_q <= err_count_d;
         err_vec_q   <= err_vec_d;
         err_ddnf_q  <= err_ddnf_d;
         err_dknf_q  <= err_dknf_d;
      end
   end

   assign bus.o_x         = x_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_done      = done_q;
   assign bus.o_error     = error_q;
   assign bus.o_err_count = err_count_q;
   assign bus.o_err_vec   = err_vec_q;
   assign bus.o_err_ddnf  = err_ddnf_q;
   assign bus.o_err_dknf  = err_dknf_q;

`ifdef SWEEP_SIG_EN
   // Shift-and-fold signature over the reference (DDNF) outputs, taken once
   // per compare cycle.
   logic [15:0] sig_q, sig_d;
   logic [15:0] w_sig_step;

   assign w_sig_step = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^
                       16'(bus.i_y_ddnf);

   always_comb begin
      sig_d = sig_q;
      if (w_start_accept)                sig_d = '0;
      else if (state_q == c_ST_COMPARE)  sig_d = w_sig_step;
   end

   always_ff @(posedge clk) begin
      if (rst) sig_q <= '0;
      else     sig_q <= sig_d;
   end

   assign bus.o_sig = sig_q;
`endif

endmodule
`default_nettype wire
